// File: rtl/f_pc_predictor_pkg.sv
// Shared definitions for the fetch-stage next-PC predictor and its return-address stack.
package f_pc_predictor_pkg;

  localparam int NIBBLE = 4;

  localparam logic [NIBBLE-1:0] IJXX  = 4'h7;
  localparam logic [NIBBLE-1:0] ICALL = 4'h8;
  localparam logic [NIBBLE-1:0] IRET  = 4'h9;

  localparam int ENABLE  = 1;
  localparam int DISABLE = 0;

  localparam int JM_TAKEN = 0;
  localparam int JM_BTFN  = 1;

  // Where the next predicted PC comes from.
  typedef enum logic [1:0] {
    PRED_SEQ      = 2'd0,
    PRED_TARGET   = 2'd1,
    PRED_RAS      = 2'd2,
    PRED_REDIRECT = 2'd3
  } pred_src_e;

  // Single resolved stack operation per cycle.
  typedef enum logic [1:0] {
    RAS_HOLD  = 2'd0,
    RAS_PUSH  = 2'd1,
    RAS_POP   = 2'd2,
    RAS_FLUSH = 2'd3
  } ras_op_e;

endpackage

// File: rtl/f_ras.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// pops on an empty stack only raise the underflow pulse.
module f_ras
  import f_pc_predictor_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4,
  localparam int PTR_W    = $clog2(RAS_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  ras_op_e          op;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  // ptr always names the next free slot, so the top lives one below it.
  assign top   = mem[ptr - PTR_ONE];
  assign count = cnt;

  always_comb begin
    op = RAS_HOLD;
    if (flush)
      op = RAS_FLUSH;
    else if (push)
      op = RAS_PUSH;
    else if (pop && !empty)
      op = RAS_POP;
  end

  // ---- stage p1: stack state and registered pulses ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++)
        mem[i] <= '0;
      ptr       <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push && !flush && full;
      underflow <= pop && !flush && !push && empty;
      case (op)
        RAS_FLUSH: begin
          ptr <= '0;
          cnt <= '0;
        end
        RAS_PUSH: begin
          mem[ptr] <= push_data;
          ptr      <= ptr + PTR_ONE;
          if (!full)
            cnt <= cnt + CNT_ONE;
        end
        RAS_POP: begin
          ptr <= ptr - PTR_ONE;
          cnt <= cnt - CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/f_pc_predictor.sv
// Fetch-stage next-PC predictor: selects between sequential, jump/call target,
// RAS top and pipeline redirect, and registers the result for fetch.
module f_pc_predictor
  import f_pc_predictor_pkg::*;
#(
  parameter int               WIDTH             = 32,
  parameter int               RAS_DEPTH         = 4,
  parameter int               JMODE             = 0,
  parameter int               FLUSH_ON_REDIRECT = 1,
  parameter logic [WIDTH-1:0] RESET_PC          = '0,
  localparam int              CNT_W             = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              F_stall_i,
  input  logic [NIBBLE-1:0] f_icode_i,
  input  logic [NIBBLE-1:0] f_ifun_i,
  input  logic [WIDTH-1:0]  f_valC_i,
  input  logic [WIDTH-1:0]  f_valP_i,
  input  logic              redirect_i,
  input  logic [WIDTH-1:0]  redirect_pc_i,
  output logic [WIDTH-1:0]  F_predPC_o,
  output logic [CNT_W-1:0]  ras_count_o,
  output logic              ras_underflow_o,
  output logic              ras_overflow_o
);

  logic             push_p0;
  logic             pop_p0;
  logic             flush_p0;
  pred_src_e        src_p0;
  logic [WIDTH-1:0] pred_nxt_p0;
  logic [WIDTH-1:0] pred_pc_p1;
  logic [WIDTH-1:0] ras_top;
  logic [CNT_W-1:0] ras_count;

  // Unconditional jumps and the always-taken policy go to the target;
  // BTFN takes only backward (lower-address) conditional targets.
  function automatic logic jxx_taken(input logic [NIBBLE-1:0] ifun,
                                     input logic [WIDTH-1:0]  valc,
                                     input logic [WIDTH-1:0]  valp);
    if (ifun == '0 || JMODE == JM_TAKEN)
      return 1'b1;
    return (valc < valp);
  endfunction

  // ---- stage p0: decode fetched instruction, pick prediction source ----
  always_comb begin
    push_p0  = 1'b0;
    pop_p0   = 1'b0;
    flush_p0 = 1'b0;
    src_p0   = PRED_SEQ;
    if (redirect_i) begin
      src_p0   = PRED_REDIRECT;
      flush_p0 = (FLUSH_ON_REDIRECT != DISABLE);
    end else if (!F_stall_i) begin
      case (f_icode_i)
        ICALL: begin
          push_p0 = 1'b1;
          src_p0  = PRED_TARGET;
        end
        IRET: begin
          pop_p0 = 1'b1;
          src_p0 = (ras_count != '0) ? PRED_RAS : PRED_SEQ;
        end
        IJXX:
          src_p0 = jxx_taken(f_ifun_i, f_valC_i, f_valP_i) ? PRED_TARGET : PRED_SEQ;
        default:
          src_p0 = PRED_SEQ;
      endcase
    end
  end

  always_comb begin
    pred_nxt_p0 = f_valP_i;
    case (src_p0)
      PRED_TARGET:   pred_nxt_p0 = f_valC_i;
      PRED_RAS:      pred_nxt_p0 = ras_top;
      PRED_REDIRECT: pred_nxt_p0 = redirect_pc_i;
      default:       pred_nxt_p0 = f_valP_i;
    endcase
  end

  // ---- stage p1: predicted-PC register ----
  always_ff @(posedge clk) begin
    if (rst)
      pred_pc_p1 <= RESET_PC;
    else if (redirect_i || !F_stall_i)
      pred_pc_p1 <= pred_nxt_p0;
  end

  f_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_p0),
    .pop       (pop_p0),
    .flush     (flush_p0),
    .push_data (f_valP_i),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow_o),
    .underflow (ras_underflow_o)
  );

  assign F_predPC_o  = pred_pc_p1;
  assign ras_count_o = ras_count;

endmodule

// File: tb/tb_f_pc_predictor.sv
// Directed plus randomized bench for f_pc_predictor against a queue-based stack model.
module tb_f_pc_predictor;

  localparam int          WIDTH     = 32;
  localparam int          DEPTH     = 4;
  localparam int          JMODE     = 1;
  localparam int          FLUSH     = 1;
  localparam logic [31:0] RESET_PC  = 32'h100;
  localparam int          CNT_W     = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             stall;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic [31:0]      valc;
  logic [31:0]      valp;
  logic             redir;
  logic [31:0]      redir_pc;
  logic [31:0]      pred_pc;
  logic [CNT_W-1:0] ras_cnt;
  logic             unf;
  logic             ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_stack[$];
  logic [31:0] m_pc;
  logic        m_ovf;
  logic        m_unf;

  f_pc_predictor #(
    .WIDTH             (WIDTH),
    .RAS_DEPTH         (DEPTH),
    .JMODE             (JMODE),
    .FLUSH_ON_REDIRECT (FLUSH),
    .RESET_PC          (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .F_stall_i       (stall),
    .f_icode_i       (icode),
    .f_ifun_i        (ifun),
    .f_valC_i        (valc),
    .f_valP_i        (valp),
    .redirect_i      (redir),
    .redirect_pc_i   (redir_pc),
    .F_predPC_o      (pred_pc),
    .ras_count_o     (ras_cnt),
    .ras_underflow_o (unf),
    .ras_overflow_o  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (rst) begin
      m_pc = RESET_PC;
      m_stack.delete();
    end else if (redir) begin
      m_pc = redir_pc;
      if (FLUSH != 0) m_stack.delete();
    end else if (!stall) begin
      case (icode)
        4'h8: begin
          if (m_stack.size() == DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
          end
          m_stack.push_back(valp);
          m_pc = valc;
        end
        4'h9: begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin
            m_pc  = valp;
            m_unf = 1'b1;
          end
        end
        4'h7: begin
          if (ifun == 4'h0 || JMODE == 0) m_pc = valc;
          else m_pc = (valc < valp) ? valc : valp;
        end
        default: m_pc = valp;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic r, input logic s, input logic rd,
                      input logic [31:0] rpc, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [31:0] c, input logic [31:0] p);
    rst = r; stall = s; redir = rd; redir_pc = rpc;
    icode = ic; ifun = fn; valc = c; valp = p;
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".pc"},  pred_pc, m_pc);
    check({tag, ".cnt"}, 32'(ras_cnt), 32'(m_stack.size()));
    check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    check({tag, ".unf"}, 32'(unf), 32'(m_unf));
  endtask

  initial begin
    m_pc = '0;
    // reset held, then a stalled first cycle keeps the reset PC
    step("rst0", 1, 0, 0, 0, 4'h8, 0, 32'h11, 32'h22);
    step("rst1", 1, 0, 0, 0, 4'h9, 0, 32'h33, 32'h44);
    step("rst2", 0, 1, 0, 0, 4'h0, 0, 32'h0,  32'h4);

    // call then ret
    step("call", 0, 0, 0, 0, 4'h8, 0, 32'h40, 32'h0A);
    step("ret",  0, 0, 0, 0, 4'h9, 0, 32'h0,  32'h41);

    // overflow and underflow on a depth-4 stack
    for (int i = 1; i <= 5; i++)
      step("ovcall", 0, 0, 0, 0, 4'h8, 0, 32'h200 + i, 32'(i * 16));
    for (int i = 0; i < 5; i++)
      step("ovret", 0, 0, 0, 0, 4'h9, 0, 32'h0, 32'h77);

    // BTFN jumps and unconditional jmp
    step("jback", 0, 0, 0, 0, 4'h7, 4'h1, 32'h08, 32'h20);
    step("jfwd",  0, 0, 0, 0, 4'h7, 4'h1, 32'h80, 32'h20);
    step("jmp",   0, 0, 0, 0, 4'h7, 4'h0, 32'h80, 32'h20);
    step("other", 0, 0, 0, 0, 4'hF, 4'h3, 32'h90, 32'h24);

    // redirect beats stall and suppresses the push
    step("precall", 0, 0, 0, 0, 4'h8, 0, 32'h60, 32'h64);
    step("redir",   0, 1, 1, 32'h3C, 4'h8, 0, 32'h70, 32'h74);

    // stalled ret pops only once released
    step("scall",  0, 0, 0, 0, 4'h8, 0, 32'h90, 32'h55);
    step("sret0",  0, 1, 0, 0, 4'h9, 0, 32'h0, 32'h99);
    step("sret1",  0, 1, 0, 0, 4'h9, 0, 32'h0, 32'h99);
    step("sret2",  0, 0, 0, 0, 4'h9, 0, 32'h0, 32'h99);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  ic;
      logic [31:0] r;
      r = $urandom_range(0, 9);
      ic = (r < 3) ? 4'h8 : (r < 6) ? 4'h9 : (r < 8) ? 4'h7 : 4'($urandom);
      step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0), $urandom, ic, 4'($urandom_range(0, 2)),
           32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
